// File: rtl/ifetch.sv
// ifetch -- instruction-fetch stage placed directly after the pc register.
//
// Takes the current pc, issues one instruction-bus request at a time, and
// captures the returned word. The word and its PC are held for decode until
// decode accepts them. On acceptance a single-cycle pc_advance pulse is
// produced; it drives pc.data_ok, so the PC only moves once a fetched
// instruction has been consumed. A misaligned pc produces a NOP with
// inst_exc set and does not touch the bus.
//
// Handshakes:
//   ireq_valid / iresp_data_ok : once ireq_valid rises, it stays high and
//     ireq_addr stays fixed until the cycle iresp_data_ok is sampled high.
//     There is never more than one request outstanding, and a request is
//     never withdrawn before its response arrives, except through reset.
//   inst_valid / inst_ready : a transfer happens on a rising edge where both
//     are high and flush is low. inst, inst_pc and inst_exc stay stable while
//     inst_valid is high and no transfer happens.
//
// Ports:
//   clk            in   clock; all state updates on the rising edge
//   reset          in   synchronous active-high reset
//   pc             in   current PC from the pc register
//   flush          in   cancel the current fetch (redirect or trap)
//   ireq_valid     out  instruction-bus request valid
//   ireq_addr      out  instruction-bus request address
//   iresp_data_ok  in   response valid for the outstanding request
//   iresp_data     in   returned instruction word
//   inst_valid     out  instruction held for decode
//   inst           out  held instruction
//   inst_pc        out  PC of the held instruction
//   inst_exc       out  held entry is an instruction-address-misaligned fault
//   inst_ready     in   decode accepts the held instruction this cycle
//   pc_advance     out  combinational acceptance pulse, drives pc.data_ok
//   inst_count     out  number of accepted instructions (wraps at 2^64)
//   fsm_state      out  current FSM state (0 IDLE, 1 WAIT, 2 FULL, 3 DRAIN)

module ifetch #(
   parameter logic [63:0] PCINIT = 64'h8000_0000,
   parameter logic [31:0] NOP    = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] pc,
   input  logic        flush,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [63:0] inst_pc,
   output logic        inst_exc,
   input  logic        inst_ready,
   output logic        pc_advance,
   output logic [63:0] inst_count,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FULL  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   assign fsm_state = state;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (flush)                 state_next = IDLE;
            else if (pc[1:0] != 2'b00) state_next = FULL;
            else                       state_next = WAIT;
         end
         WAIT: begin
            if (iresp_data_ok && !flush)      state_next = FULL;
            else if (iresp_data_ok && flush)  state_next = IDLE;
            else if (flush)                   state_next = DRAIN;
            else                              state_next = WAIT;
         end
         FULL: begin
            // flush wins over acceptance: the held entry is simply dropped.
            if (flush || inst_ready) state_next = IDLE;
            else                     state_next = FULL;
         end
         DRAIN: begin
            // The abandoned request must still complete; flush is moot here.
            if (iresp_data_ok) state_next = IDLE;
            else               state_next = DRAIN;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic.
   always_comb begin
      ireq_valid = 1'b0;
      inst_valid = 1'b0;
      pc_advance = 1'b0;
      case (state)
         WAIT:  ireq_valid = 1'b1;
         DRAIN: ireq_valid = 1'b1;
         FULL: begin
            inst_valid = 1'b1;
            pc_advance = inst_ready & ~flush;
         end
         default: ;
      endcase
   end

   // Datapath registers: request address, held entry, accept counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         ireq_addr  <= 64'd0;
         inst       <= 32'd0;
         inst_pc    <= PCINIT;
         inst_exc   <= 1'b0;
         inst_count <= 64'd0;
      end else begin
         case (state)
            IDLE: begin
               if (!flush) begin
                  if (pc[1:0] != 2'b00) begin
                     inst     <= NOP;
                     inst_pc  <= pc;
                     inst_exc <= 1'b1;
                  end else begin
                     ireq_addr <= pc;
                  end
               end
            end
            WAIT: begin
               if (iresp_data_ok && !flush) begin
                  inst     <= iresp_data;
                  inst_pc  <= ireq_addr;
                  inst_exc <= 1'b0;
               end
            end
            FULL: begin
               if (pc_advance) begin
                  inst_count <= inst_count + 64'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

  localparam logic [63:0] PCINIT = 64'h8000_0000;

  logic        clk;
  logic        reset;
  logic [63:0] pc;
  logic        flush;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_exc;
  logic        inst_ready;
  logic        pc_advance;
  logic [63:0] inst_count;
  logic [1:0]  fsm_state;

  int vectors;
  int miscompares;

  ifetch dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .flush         (flush),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_exc      (inst_exc),
    .inst_ready    (inst_ready),
    .pc_advance    (pc_advance),
    .inst_count    (inst_count),
    .fsm_state     (fsm_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    pc            = 64'h0;
    flush         = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = 32'h0;
    inst_ready    = 1'b1;

    // Reset values
    cyc();
    cyc();
    settle();
    chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("rst_ireq_addr",  ireq_addr, 64'd0);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_inst",       {32'd0, inst}, 64'd0);
    chk("rst_inst_pc",    inst_pc, PCINIT);
    chk("rst_inst_exc",   {63'd0, inst_exc}, 64'd0);
    chk("rst_pc_advance", {63'd0, pc_advance}, 64'd0);
    chk("rst_count",      inst_count, 64'd0);
    chk("rst_state",      {62'd0, fsm_state}, 64'd0);

    // Zero-wait fetch, always-ready decode
    reset = 1'b0;
    pc    = 64'h8000_0000;
    cyc();                                     // IDLE -> WAIT
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h0000_0513;
    settle();
    chk("t1_req_valid", {63'd0, ireq_valid}, 64'd1);
    chk("t1_req_addr",  ireq_addr, 64'h8000_0000);
    cyc();                                     // WAIT -> FULL
    iresp_data_ok = 1'b0;
    settle();
    chk("t1_req_drop",   {63'd0, ireq_valid}, 64'd0);
    chk("t1_inst_valid", {63'd0, inst_valid}, 64'd1);
    chk("t1_inst",       {32'd0, inst}, 64'h0000_0513);
    chk("t1_inst_pc",    inst_pc, 64'h8000_0000);
    chk("t1_inst_exc",   {63'd0, inst_exc}, 64'd0);
    chk("t1_pc_advance", {63'd0, pc_advance}, 64'd1);
    cyc();                                     // FULL -> IDLE, pc moves
    pc = 64'h8000_0004;
    settle();
    chk("t1_count",      inst_count, 64'd1);
    chk("t1_idle_valid", {63'd0, inst_valid}, 64'd0);
    chk("t1_idle_adv",   {63'd0, pc_advance}, 64'd0);

    // Bus response delayed 4 cycles
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 4) begin
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0010_0093;
      end
      settle();
      chk("t2_req_valid", {63'd0, ireq_valid}, 64'd1);
      chk("t2_req_addr",  ireq_addr, 64'h8000_0004);
      chk("t2_no_inst",   {63'd0, inst_valid}, 64'd0);
    end

    // Decode stalls 3 cycles in FULL
    cyc();
    iresp_data_ok = 1'b0;
    inst_ready    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_inst_valid", {63'd0, inst_valid}, 64'd1);
      chk("t3_inst",       {32'd0, inst}, 64'h0010_0093);
      chk("t3_inst_pc",    inst_pc, 64'h8000_0004);
      chk("t3_no_adv",     {63'd0, pc_advance}, 64'd0);
      chk("t3_no_req",     {63'd0, ireq_valid}, 64'd0);
      cyc();
    end
    inst_ready = 1'b1;
    settle();
    chk("t3_inst_held", {32'd0, inst}, 64'h0010_0093);
    chk("t3_adv",       {63'd0, pc_advance}, 64'd1);
    chk("t3_count_pre", inst_count, 64'd1);
    cyc();
    pc = 64'h8000_0008;
    settle();
    chk("t3_count", inst_count, 64'd2);

    // Flush in first WAIT cycle, late response discarded in DRAIN
    cyc();                                     // IDLE -> WAIT
    flush = 1'b1;
    settle();
    chk("t4_req_addr", ireq_addr, 64'h8000_0008);
    cyc();                                     // WAIT -> DRAIN
    flush = 1'b0;
    pc    = 64'h8000_0100;
    settle();
    chk("t4_drain_req",  {63'd0, ireq_valid}, 64'd1);
    chk("t4_drain_addr", ireq_addr, 64'h8000_0008);
    chk("t4_drain_st",   {62'd0, fsm_state}, 64'd3);
    cyc();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hDEAD_BEEF;
    settle();
    chk("t4_drain_req2", {63'd0, ireq_valid}, 64'd1);
    chk("t4_no_inst",    {63'd0, inst_valid}, 64'd0);
    cyc();                                     // DRAIN -> IDLE
    iresp_data_ok = 1'b0;
    settle();
    chk("t4_idle_req",  {63'd0, ireq_valid}, 64'd0);
    chk("t4_no_inst2",  {63'd0, inst_valid}, 64'd0);
    chk("t4_inst_kept", {32'd0, inst}, 64'h0010_0093);
    cyc();                                     // IDLE -> WAIT on redirect
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h0020_0113;
    settle();
    chk("t4_redirect_addr", ireq_addr, 64'h8000_0100);
    cyc();                                     // WAIT -> FULL
    iresp_data_ok = 1'b0;
    inst_ready    = 1'b1;
    flush         = 1'b1;

    // flush and inst_ready together in FULL
    settle();
    chk("t6_inst",    {32'd0, inst}, 64'h0020_0113);
    chk("t6_inst_pc", inst_pc, 64'h8000_0100);
    chk("t6_no_adv",  {63'd0, pc_advance}, 64'd0);
    cyc();
    flush      = 1'b0;
    pc         = 64'h8000_0002;
    inst_ready = 1'b0;
    settle();
    chk("t6_count", inst_count, 64'd2);
    chk("t6_state", {62'd0, fsm_state}, 64'd0);
    chk("t6_valid", {63'd0, inst_valid}, 64'd0);

    // Misaligned pc: NOP with exception, no bus request
    cyc();
    inst_ready = 1'b1;
    settle();
    chk("t5_no_req",   {63'd0, ireq_valid}, 64'd0);
    chk("t5_valid",    {63'd0, inst_valid}, 64'd1);
    chk("t5_exc",      {63'd0, inst_exc}, 64'd1);
    chk("t5_inst",     {32'd0, inst}, 64'h0000_0013);
    chk("t5_inst_pc",  inst_pc, 64'h8000_0002);
    chk("t5_adv",      {63'd0, pc_advance}, 64'd1);
    chk("t5_req_addr", ireq_addr, 64'h8000_0100);
    cyc();
    flush = 1'b1;
    pc    = 64'h8000_0010;
    settle();
    chk("t5_count", inst_count, 64'd3);

    // flush held in IDLE keeps the stage idle
    cyc();
    settle();
    chk("idle_flush_state", {62'd0, fsm_state}, 64'd0);
    chk("idle_flush_req",   {63'd0, ireq_valid}, 64'd0);
    flush = 1'b0;

    // Reset while a request is outstanding
    cyc();
    settle();
    chk("rw_req", {63'd0, ireq_valid}, 64'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    settle();
    chk("rw_req_drop", {63'd0, ireq_valid}, 64'd0);
    chk("rw_state",    {62'd0, fsm_state}, 64'd0);
    chk("rw_count",    inst_count, 64'd0);
    chk("rw_inst_pc",  inst_pc, PCINIT);
    chk("rw_exc",      {63'd0, inst_exc}, 64'd0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
